// File: rtl/split_pkg.sv
// Shared definitions for the split_fields word splitter.
// Holds field widths, field index constants, the bit-offset table of each
// field inside the packed word, and the control state encoding.
package split_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned FIELD_W    = 8;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned NUM_FIELDS = 5;
    localparam int unsigned IDX_W      = 3;

    localparam logic [IDX_W-1:0] FIELD_A = 3'd0;
    localparam logic [IDX_W-1:0] FIELD_B = 3'd1;
    localparam logic [IDX_W-1:0] FIELD_C = 3'd2;
    localparam logic [IDX_W-1:0] FIELD_D = 3'd3;
    localparam logic [IDX_W-1:0] FIELD_E = 3'd4;

    // LSB position of each field inside the packed word, indexed A..E.
    localparam int unsigned FIELD_OFS [NUM_FIELDS] = '{24, 16, 8, 4, 0};

    typedef enum logic {
        EMPTY,
        BUSY
    } state_t;

endpackage

// File: rtl/split_fields_field_select.sv
// Combinational field extractor.
// Ports:
//   word  - held packed word (A,B,C byte fields, D,E nibble fields)
//   idx   - field index, FIELD_A..FIELD_E
//   field - selected field; nibble fields zero-extended, out-of-range idx gives 0
module field_select
    import split_pkg::*;
(
    input  logic [WORD_W-1:0]  word,
    input  logic [IDX_W-1:0]   idx,
    output logic [FIELD_W-1:0] field
);

    always_comb begin
        field = '0;
        case (idx)
            FIELD_A: field = word[FIELD_OFS[FIELD_A] +: FIELD_W];
            FIELD_B: field = word[FIELD_OFS[FIELD_B] +: FIELD_W];
            FIELD_C: field = word[FIELD_OFS[FIELD_C] +: FIELD_W];
            FIELD_D: field = {{(FIELD_W-NIB_W){1'b0}}, word[FIELD_OFS[FIELD_D] +: NIB_W]};
            FIELD_E: field = {{(FIELD_W-NIB_W){1'b0}}, word[FIELD_OFS[FIELD_E] +: NIB_W]};
            default: field = '0;
        endcase
    end

endmodule

// File: rtl/split_fields.sv
// Splits a 32-bit packed word into five fields (A,B,C bytes, D,E nibbles)
// and streams them out one per output handshake, idx 0..4.
// Ports:
//   Clk, Rst             - clock, synchronous active-high reset
//   InWord/InValid/InReady   - input word handshake
//   OutField/OutIdx/OutLast/OutValid/OutReady - output field handshake
module split_fields
    import split_pkg::*;
(
    input  logic               Clk,
    input  logic               Rst,
    input  logic [WORD_W-1:0]  InWord,
    input  logic               InValid,
    output logic               InReady,
    output logic [FIELD_W-1:0] OutField,
    output logic [IDX_W-1:0]   OutIdx,
    output logic               OutLast,
    output logic               OutValid,
    input  logic               OutReady
);

    state_t            state;
    state_t            state_nx;
    logic [WORD_W-1:0] hold;
    logic [IDX_W-1:0]  idx;
    logic              last;
    logic              in_hs;
    logic              out_hs;

    always_comb begin
        last     = (idx == FIELD_E);
        OutValid = (state == BUSY);
        // A new word is taken while the last field drains, giving no bubble.
        InReady  = !Rst && ((state == EMPTY) || (last && OutReady));
        in_hs    = InValid && InReady;
        out_hs   = OutValid && OutReady;
        state_nx = state;
        case (state)
            EMPTY: if (in_hs) state_nx = BUSY;
            BUSY:  if (out_hs && last && !in_hs) state_nx = EMPTY;
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= EMPTY;
            hold  <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            if (in_hs) begin
                hold <= InWord;
                idx  <= '0;
            end else if (out_hs && !last) begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    field_select u_field_select (
        .word  (hold),
        .idx   (idx),
        .field (OutField)
    );

    assign OutIdx  = idx;
    assign OutLast = last;

endmodule

// File: tb/tb_split_fields.sv
// Self-checking bench for split_fields: table-driven single words,
// then directed backpressure, back-to-back, reset mid-word and a random
// round trip against a scoreboard.
module tb_split_fields;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] InWord;
    logic        InValid;
    logic        InReady;
    logic [7:0]  OutField;
    logic [2:0]  OutIdx;
    logic        OutLast;
    logic        OutValid;
    logic        OutReady;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    always #5 Clk = ~Clk;

    split_fields dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .InWord   (InWord),
        .InValid  (InValid),
        .InReady  (InReady),
        .OutField (OutField),
        .OutIdx   (OutIdx),
        .OutLast  (OutLast),
        .OutValid (OutValid),
        .OutReady (OutReady)
    );

    typedef struct {
        logic [31:0] word;
        logic [39:0] fields;   // field 0 in [39:32] ... field 4 in [7:0]
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Capture one word with OutReady=1 and check its five fields.
    task automatic run_word(input logic [31:0] w, input logic [39:0] exp, input string nm);
        logic [7:0] e;
        InWord   = w;
        InValid  = 1'b1;
        OutReady = 1'b1;
        #1;
        chk({nm, " inready_empty"}, 32'(InReady), 32'd1);
        step();
        InValid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            e = exp[39 - 8*k -: 8];
            chk({nm, " valid"}, 32'(OutValid), 32'd1);
            chk({nm, " field"}, 32'(OutField), 32'(e));
            chk({nm, " idx"},   32'(OutIdx),   32'(k));
            chk({nm, " last"},  32'(OutLast),  32'(k == 4));
            step();
        end
        chk({nm, " done_valid"}, 32'(OutValid), 32'd0);
    endtask

    vec_t vecs [5];

    initial begin
        logic [7:0]  b2b [10];
        logic [7:0]  fa, fb, fc;
        logic [3:0]  fd, fe;
        logic [10:0] sb [$];
        logic [10:0] ent;
        int unsigned sent, got, cyc;
        logic        pend, ihs, ohs;

        vecs[0] = '{32'hFFAA550F, 40'hFF_AA_55_00_0F};
        vecs[1] = '{32'h12345678, 40'h12_34_56_07_08};
        vecs[2] = '{32'h00000000, 40'h00_00_00_00_00};
        vecs[3] = '{32'hFFFFFFFF, 40'hFF_FF_FF_0F_0F};
        vecs[4] = '{32'hA5C3E71B, 40'hA5_C3_E7_01_0B};

        Rst = 1'b1; InWord = 32'hDEADBEEF; InValid = 1'b1; OutReady = 1'b1;
        step();
        step();
        chk("rst valid",   32'(OutValid), 32'd0);
        chk("rst field",   32'(OutField), 32'd0);
        chk("rst idx",     32'(OutIdx),   32'd0);
        chk("rst last",    32'(OutLast),  32'd0);
        chk("rst inready", 32'(InReady),  32'd0);
        Rst = 1'b0; InValid = 1'b0;
        #1;
        chk("post_rst inready", 32'(InReady), 32'd1);
        chk("post_rst valid",   32'(OutValid), 32'd0);

        for (int i = 0; i < 5; i++)
            run_word(vecs[i].word, vecs[i].fields, $sformatf("vec%0d", i));

        // Backpressure at idx 2.
        InWord = 32'hFFAA550F; InValid = 1'b1; OutReady = 1'b1;
        step();
        InValid = 1'b0;
        chk("bp f0", 32'(OutField), 32'hFF);
        step();
        chk("bp f1", 32'(OutField), 32'hAA);
        step();
        OutReady = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("bp hold field",   32'(OutField), 32'h55);
            chk("bp hold idx",     32'(OutIdx),   32'd2);
            chk("bp hold inready", 32'(InReady),  32'd0);
            chk("bp hold valid",   32'(OutValid), 32'd1);
            step();
        end
        OutReady = 1'b1;
        #1;
        chk("bp f2", 32'(OutField), 32'h55);
        step();
        chk("bp f3", 32'(OutField), 32'h00);
        chk("bp i3", 32'(OutIdx),   32'd3);
        step();
        chk("bp f4", 32'(OutField), 32'h0F);
        chk("bp l4", 32'(OutLast),  32'd1);
        step();
        chk("bp done", 32'(OutValid), 32'd0);

        // Back-to-back words with InValid held high.
        b2b = '{8'h12, 8'h34, 8'h56, 8'h07, 8'h08, 8'h9A, 8'hBC, 8'hDE, 8'h0F, 8'h00};
        InWord = 32'h12345678; InValid = 1'b1; OutReady = 1'b1;
        step();
        InWord = 32'h9ABCDEF0;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("b2b valid", 32'(OutValid), 32'd1);
            chk("b2b field", 32'(OutField), 32'(b2b[i]));
            chk("b2b idx",   32'(OutIdx),   32'(i % 5));
            chk("b2b last",  32'(OutLast),  32'(i % 5 == 4));
            if (i == 4)
                chk("b2b inready_idx4", 32'(InReady), 32'd1);
            else if (i < 4)
                chk("b2b inready_busy", 32'(InReady), 32'd0);
            step();
            if (i == 4) InValid = 1'b0;
        end
        chk("b2b done", 32'(OutValid), 32'd0);

        // Reset pulsed at idx 1 of a word.
        InWord = 32'hFFAA550F; InValid = 1'b1; OutReady = 1'b1;
        step();
        InValid = 1'b0;
        chk("rmw f0", 32'(OutField), 32'hFF);
        step();
        chk("rmw f1", 32'(OutField), 32'hAA);
        Rst = 1'b1; InValid = 1'b1; InWord = 32'h77777777;
        step();
        chk("rmw rst valid", 32'(OutValid), 32'd0);
        Rst = 1'b0; InValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rmw no_fields", 32'(OutValid), 32'd0);
            chk("rmw field0",    32'(OutField), 32'd0);
        end
        run_word(32'h01020304, 40'h01_02_03_00_04, "rmw next");

        // Random round trip against a scoreboard of expected {idx, field}.
        sent = 0; got = 0; cyc = 0; pend = 1'b0;
        InValid = 1'b0;
        while ((got < 5000) && (cyc < 40000)) begin
            if (!pend && sent < 1000 && ($urandom_range(0, 3) != 0)) begin
                fa = 8'($urandom); fb = 8'($urandom); fc = 8'($urandom);
                fd = 4'($urandom); fe = 4'($urandom);
                InWord = {fa, fb, fc, fd, fe};
                pend = 1'b1;
            end
            InValid  = pend;
            OutReady = ($urandom_range(0, 2) != 0);
            #1;
            ihs = InValid && InReady;
            ohs = OutValid && OutReady;
            if (ohs) begin
                if (sb.size() == 0) begin
                    chk("rt unexpected_field", 32'(OutField), 32'hFFFFFFFF);
                end else begin
                    ent = sb.pop_front();
                    chk("rt field", 32'(OutField), 32'(ent[7:0]));
                    chk("rt idx",   32'(OutIdx),   32'(ent[10:8]));
                    chk("rt last",  32'(OutLast),  32'(ent[10:8] == 3'd4));
                    got++;
                end
            end
            if (ihs) begin
                sb.push_back({3'd0, fa});
                sb.push_back({3'd1, fb});
                sb.push_back({3'd2, fc});
                sb.push_back({3'd3, 4'd0, fd});
                sb.push_back({3'd4, 4'd0, fe});
                sent++;
                pend = 1'b0;
            end
            step();
            cyc++;
        end
        InValid = 1'b0;
        chk("rt words_sent", sent, 32'd1000);
        chk("rt fields_got", got,  32'd5000);
        chk("rt sb_empty",   32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/split_fields.md
SPLIT_FIELDS -- requirements
Module: split_fields

Interface
REQ-001 Parameters: none; all field widths and positions SHALL come from the shared package.
REQ-002 Clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Rst  input  1  synchronous, active-high reset.
REQ-004 InWord  input  32  packed word; A = most significant byte, then B, C, D = next nibble, E = least significant nibble.
REQ-005 InValid  input  1  InWord is valid this cycle.
REQ-006 InReady  output  1  block accepts InWord this cycle.
REQ-007 OutField  output  8  current field value; D and E zero-extended in the upper 4 bits.
REQ-008 OutIdx  output  3  current field index: A=0, B=1, C=2, D=3, E=4.
REQ-009 OutLast  output  1  high while OutIdx=4.
REQ-010 OutValid  output  1  OutField, OutIdx and OutLast are valid.
REQ-011 OutReady  input  1  downstream accepts the current field.

Function
REQ-012 An input handshake SHALL occur on a rising edge where InValid=1 and InReady=1; the block SHALL capture InWord into a holding register.
REQ-013 An output handshake SHALL occur on a rising edge where OutValid=1 and OutReady=1.
REQ-014 The state machine SHALL have two states:
- EMPTY: no word held; OutValid=0.
- BUSY: word held; OutValid=1.
REQ-015 Transitions: EMPTY->BUSY on input handshake; BUSY->EMPTY on the idx-4 output handshake unless a new input handshake occurs on the same edge.
REQ-016 InReady SHALL be 1 in EMPTY, and 1 in BUSY only when the field index is 4 and OutReady=1; this is a combinational path from OutReady.
REQ-017 After a captured word, the first field (idx 0, value A) SHALL be presented with OutValid=1 in the cycle after the capture edge.
REQ-018 The field index SHALL reset to 0 on every capture, increment by 1 on each non-last output handshake, and never exceed 4.
REQ-019 While OutValid=1 and OutReady=0, OutField, OutIdx and OutLast SHALL hold stable.
REQ-020 On the idx-4 output handshake with InValid=1, the block SHALL capture the new word and present its idx 0 on the next cycle with no bubble; sustained throughput SHALL be 1 word per 5 cycles.
REQ-021 When InValid=1 and InReady=0, the block SHALL NOT capture or alter any state, and upstream SHALL hold InWord.
REQ-022 OutField SHALL be a pure function of the held word and the index; no arithmetic is performed, and upper bits for D and E SHALL be 0.
REQ-023 Word boundaries SHALL be indicated only by OutLast; no other output SHALL indicate a word boundary.

Reset
REQ-024 While Rst=1 at a clock edge, the block SHALL set: state=EMPTY, index=0, holding register=0; outputs SHALL be OutValid=0, OutField=0, OutIdx=0, OutLast=0.
REQ-025 InReady SHALL be 0 while Rst is asserted and SHALL be 1 in the first cycle after Rst deasserts.
REQ-026 A reset during BUSY SHALL discard the held word, and no remaining fields of that word SHALL appear afterwards.
REQ-027 A handshake coincident with Rst=1 SHALL be ignored.

Structure
REQ-028 Package split_pkg SHALL hold:
- WORD_W=32, FIELD_W=8, NIB_W=4, NUM_FIELDS=5, IDX_W=3;
- field index constants FIELD_A..FIELD_E (0..4);
- a field-offset table;
- the state enum {EMPTY, BUSY}.
REQ-029 Combinational sub-module field_select (held word, index -> OutField) SHALL be used; the control FSM, index counter and holding register SHALL stay in split_fields.

Verification
REQ-030 Single word: after reset, InWord=0xFFAA550F, OutReady=1 -> fields FF,AA,55,00,0F on idx 0..4 in 5 consecutive cycles, OutLast only on 0F.
REQ-031 Backpressure: OutReady=0 for 3 cycles at idx 2 -> OutField=0x55 and OutIdx=2 held throughout; InReady=0; sequence then resumes 00,0F.
REQ-032 Back-to-back: 0x12345678 then 0x9ABCDEF0 with InValid held high -> 12,34,56,07,08,9A,BC,DE,0F,00 in 10 consecutive cycles; second capture on the idx-4 edge.
REQ-033 Reset mid-word: Rst pulsed 1 cycle at idx 1 of 0xFFAA550F -> OutValid=0 next cycle, no further fields; next word 0x01020304 emits 01,02,03,00,04.
REQ-034 Round trip: random A..E packed as A,B,C,D,E into 32 bits, 1000 words with random InValid/OutReady -> emitted fields equal A..E in order, none lost or duplicated.
